// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs feeding one registered broadcast
// per cycle, chosen oldest-first by ROB age, with partial and full flush support.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_FU-1:0]                      i_fu_valid,
  output logic [NUM_FU-1:0]                      o_fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]                i_fu_tag,
  input  logic [NUM_FU*64-1:0]                   i_fu_value,
  input  logic [NUM_FU-1:0]                      i_fu_exception,
  input  logic [NUM_FU*5-1:0]                    i_fu_exc_cause,
  input  logic [NUM_FU*5-1:0]                    i_fu_fflags,
  input  logic                                   i_flush_en,
  input  logic [TAG_W-1:0]                       i_flush_tag,
  input  logic [TAG_W-1:0]                       i_rob_head_tag,
  input  logic                                   i_flush_all,
  output logic                                   o_cdb_valid,
  output logic [TAG_W-1:0]                       o_cdb_tag,
  output logic [63:0]                            o_cdb_value,
  output logic                                   o_cdb_exception,
  output logic [4:0]                             o_cdb_exc_cause,
  output logic [4:0]                             o_cdb_fflags,
  output logic [$clog2(NUM_FU*FIFO_DEPTH+1)-1:0] o_pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = $clog2(NUM_FU);
  localparam int CW = $clog2(NUM_FU*FIFO_DEPTH+1);

  logic [AW:0]             wptr      [NUM_FU];
  logic [AW:0]             rptr      [NUM_FU];
  logic [FIFO_DEPTH-1:0]   ent_live  [NUM_FU];
  logic [TAG_W-1:0]        ent_tag   [NUM_FU][FIFO_DEPTH];
  logic [63:0]             ent_value [NUM_FU][FIFO_DEPTH];
  logic                    ent_exc   [NUM_FU][FIFO_DEPTH];
  logic [4:0]              ent_cause [NUM_FU][FIFO_DEPTH];
  logic [4:0]              ent_ff    [NUM_FU][FIFO_DEPTH];

  logic [TAG_W-1:0]        flush_age;
  logic [AW-1:0]           head_idx  [NUM_FU];
  logic [TAG_W-1:0]        head_age  [NUM_FU];
  logic [TAG_W-1:0]        in_age    [NUM_FU];
  logic [AW:0]             wptr_nxt  [NUM_FU];
  logic [AW:0]             rptr_nxt  [NUM_FU];
  logic [FIFO_DEPTH-1:0]   live_nxt  [NUM_FU];
  logic [NUM_FU-1:0]       empty, head_ok, pop, push, full_nxt;
  logic                    win_found;
  logic [KW-1:0]           win_k;
  logic [TAG_W-1:0]        win_age;
  logic [AW-1:0]           win_idx;
  logic [CW-1:0]           pending_cnt;

  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] t,
                                               input logic [TAG_W-1:0] h);
    return t - h;
  endfunction

  // Oldest eligible head wins; strict less-than keeps the lowest index on ties.
  always_comb begin
    flush_age = age_of(i_flush_tag, i_rob_head_tag);
    win_found = 1'b0;
    win_k     = '0;
    win_age   = '0;
    empty     = '0;
    head_ok   = '0;
    pop       = '0;
    push      = '0;
    full_nxt  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      head_idx[k] = rptr[k][AW-1:0];
      head_age[k] = age_of(ent_tag[k][rptr[k][AW-1:0]], i_rob_head_tag);
      in_age[k]   = age_of(i_fu_tag[k*TAG_W +: TAG_W], i_rob_head_tag);
      empty[k]    = (wptr[k] == rptr[k]);
      head_ok[k]  = !empty[k] && ent_live[k][rptr[k][AW-1:0]] && !i_flush_all &&
                    !(i_flush_en && (head_age[k] > flush_age));
      if (head_ok[k] && (!win_found || (head_age[k] < win_age))) begin
        win_found = 1'b1;
        win_k     = KW'(k);
        win_age   = head_age[k];
      end
    end
    for (int k = 0; k < NUM_FU; k++) begin
      pop[k]  = !empty[k] && (!head_ok[k] || (win_k == KW'(k)));
      push[k] = i_fu_valid[k] && o_fu_ready[k] && !i_flush_all &&
                !(i_flush_en && (in_age[k] > flush_age));
      wptr_nxt[k] = wptr[k] + (AW+1)'(push[k]);
      rptr_nxt[k] = rptr[k] + (AW+1)'(pop[k]);
      full_nxt[k] = (wptr_nxt[k][AW] != rptr_nxt[k][AW]) &&
                    (wptr_nxt[k][AW-1:0] == rptr_nxt[k][AW-1:0]);
    end
    win_idx = head_idx[win_k];
  end

  // Entry valid bits: flush squash, then pop, then the new push slot.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      live_nxt[k] = ent_live[k];
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        if (i_flush_en && (age_of(ent_tag[k][d], i_rob_head_tag) > flush_age))
          live_nxt[k][d] = 1'b0;
      end
      if (pop[k])  live_nxt[k][head_idx[k]] = 1'b0;
      if (push[k]) live_nxt[k][wptr[k][AW-1:0]] = 1'b1;
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int k = 0; k < NUM_FU; k++)
      for (int d = 0; d < FIFO_DEPTH; d++)
        pending_cnt = pending_cnt + CW'(ent_live[k][d]);
  end

  assign o_pending = pending_cnt;

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if (push[k]) begin
        ent_tag[k][wptr[k][AW-1:0]]   <= i_fu_tag[k*TAG_W +: TAG_W];
        ent_value[k][wptr[k][AW-1:0]] <= i_fu_value[k*64 +: 64];
        ent_exc[k][wptr[k][AW-1:0]]   <= i_fu_exception[k];
        ent_cause[k][wptr[k][AW-1:0]] <= i_fu_exc_cause[k*5 +: 5];
        ent_ff[k][wptr[k][AW-1:0]]    <= i_fu_fflags[k*5 +: 5];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_FU; k++) begin
        wptr[k]     <= '0;
        rptr[k]     <= '0;
        ent_live[k] <= '0;
      end
      o_fu_ready      <= '1;
      o_cdb_valid     <= 1'b0;
      o_cdb_tag       <= '0;
      o_cdb_value     <= '0;
      o_cdb_exception <= 1'b0;
      o_cdb_exc_cause <= '0;
      o_cdb_fflags    <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (i_flush_all) begin
          wptr[k]       <= '0;
          rptr[k]       <= '0;
          ent_live[k]   <= '0;
          o_fu_ready[k] <= 1'b1;
        end else begin
          wptr[k]       <= wptr_nxt[k];
          rptr[k]       <= rptr_nxt[k];
          ent_live[k]   <= live_nxt[k];
          o_fu_ready[k] <= !full_nxt[k];
        end
      end
      o_cdb_valid <= win_found;
      if (win_found) begin
        o_cdb_tag       <= ent_tag[win_k][win_idx];
        o_cdb_value     <= ent_value[win_k][win_idx];
        o_cdb_exception <= ent_exc[win_k][win_idx];
        o_cdb_exc_cause <= ent_cause[win_k][win_idx];
        o_cdb_fflags    <= ent_ff[win_k][win_idx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based model of the oldest-first broadcast rules.
module tb_cdb_arbiter;

  localparam int NUM_FU     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = 5;
  localparam int CW         = $clog2(NUM_FU*FIFO_DEPTH+1);

  logic                      clk;
  logic                      rst_n;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU-1:0]         fu_ready;
  logic [NUM_FU*TAG_W-1:0]   fu_tag;
  logic [NUM_FU*64-1:0]      fu_value;
  logic [NUM_FU-1:0]         fu_exception;
  logic [NUM_FU*5-1:0]       fu_exc_cause;
  logic [NUM_FU*5-1:0]       fu_fflags;
  logic                      flush_en;
  logic [TAG_W-1:0]          flush_tag;
  logic [TAG_W-1:0]          rob_head;
  logic                      flush_all;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [63:0]               cdb_value;
  logic                      cdb_exception;
  logic [4:0]                cdb_exc_cause;
  logic [4:0]                cdb_fflags;
  logic [CW-1:0]             pending;

  cdb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fu_valid(fu_valid), .o_fu_ready(fu_ready),
    .i_fu_tag(fu_tag), .i_fu_value(fu_value),
    .i_fu_exception(fu_exception), .i_fu_exc_cause(fu_exc_cause), .i_fu_fflags(fu_fflags),
    .i_flush_en(flush_en), .i_flush_tag(flush_tag), .i_rob_head_tag(rob_head),
    .i_flush_all(flush_all),
    .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag), .o_cdb_value(cdb_value),
    .o_cdb_exception(cdb_exception), .o_cdb_exc_cause(cdb_exc_cause),
    .o_cdb_fflags(cdb_fflags), .o_pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      value;
    logic             exc;
    logic [4:0]       cause;
    logic [4:0]       ff;
    bit               alive;
  } ent_t;

  ent_t              q [NUM_FU][$];
  bit                exp_valid;
  ent_t              exp_ent;
  logic [NUM_FU-1:0] exp_ready;
  int                exp_pending;
  int                checks;
  int                failures;

  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] t);
    return TAG_W'(t - rob_head);
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_FU; k++) q[k].delete();
    exp_valid   = 1'b0;
    exp_ready   = '1;
    exp_pending = 0;
  endtask

  // One clock edge of the broadcast rules, using the inputs currently driven.
  task automatic model_step();
    logic [TAG_W-1:0] fa;
    logic [TAG_W-1:0] best_age;
    int               best;
    bit               live [NUM_FU];
    bit               rdy  [NUM_FU];
    ent_t             e;
    fa = age(flush_tag);
    for (int k = 0; k < NUM_FU; k++) rdy[k] = (q[k].size() < FIFO_DEPTH);
    if (flush_all) begin
      for (int k = 0; k < NUM_FU; k++) q[k].delete();
      exp_valid = 1'b0;
    end else begin
      best = -1;
      best_age = '0;
      for (int k = 0; k < NUM_FU; k++) begin
        live[k] = 1'b0;
        if (q[k].size() > 0)
          live[k] = q[k][0].alive && !(flush_en && (age(q[k][0].tag) > fa));
        if (live[k] && (best < 0 || age(q[k][0].tag) < best_age)) begin
          best = k;
          best_age = age(q[k][0].tag);
        end
      end
      exp_valid = (best >= 0);
      if (best >= 0) exp_ent = q[best][0];
      for (int k = 0; k < NUM_FU; k++)
        if (q[k].size() > 0 && (k == best || !live[k])) void'(q[k].pop_front());
      if (flush_en)
        for (int k = 0; k < NUM_FU; k++)
          for (int i = 0; i < q[k].size(); i++)
            if (age(q[k][i].tag) > fa) begin
              e = q[k][i];
              e.alive = 1'b0;
              q[k][i] = e;
            end
      for (int k = 0; k < NUM_FU; k++)
        if (fu_valid[k] && rdy[k]) begin
          e.tag   = fu_tag[k*TAG_W +: TAG_W];
          e.value = fu_value[k*64 +: 64];
          e.exc   = fu_exception[k];
          e.cause = fu_exc_cause[k*5 +: 5];
          e.ff    = fu_fflags[k*5 +: 5];
          e.alive = 1'b1;
          if (!(flush_en && (age(e.tag) > fa))) q[k].push_back(e);
        end
    end
    exp_pending = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      exp_ready[k] = (q[k].size() < FIFO_DEPTH);
      for (int i = 0; i < q[k].size(); i++) if (q[k][i].alive) exp_pending++;
    end
  endtask

  task automatic checkOutput();
    check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("cdb_tag",   64'(cdb_tag),       64'(exp_ent.tag));
      check("cdb_value", cdb_value,          exp_ent.value);
      check("cdb_exc",   64'(cdb_exception), 64'(exp_ent.exc));
      check("cdb_cause", 64'(cdb_exc_cause), 64'(exp_ent.cause));
      check("cdb_ff",    64'(cdb_fflags),    64'(exp_ent.ff));
    end
    check("fu_ready", 64'(fu_ready), 64'(exp_ready));
    check("pending",  64'(pending),  64'(exp_pending));
  endtask

  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clear_inputs();
    fu_valid = '0; fu_tag = '0; fu_value = '0; fu_exception = '0;
    fu_exc_cause = '0; fu_fflags = '0;
    flush_en = 1'b0; flush_tag = '0; flush_all = 1'b0;
  endtask

  task automatic set_fu(input int k, input logic [TAG_W-1:0] tag, input logic [63:0] value);
    fu_valid[k]              = 1'b1;
    fu_tag[k*TAG_W +: TAG_W] = tag;
    fu_value[k*64 +: 64]     = value;
    fu_exception[k]          = value[0];
    fu_exc_cause[k*5 +: 5]   = value[8:4];
    fu_fflags[k*5 +: 5]      = value[16:12];
  endtask

  task automatic random_inputs();
    clear_inputs();
    for (int k = 0; k < NUM_FU; k++)
      if ($urandom_range(0, 1) == 1) set_fu(k, TAG_W'($urandom), {$urandom, $urandom});
    if ($urandom_range(0, 7) == 0) rob_head = rob_head + TAG_W'($urandom_range(1, 4));
    flush_en  = ($urandom_range(0, 19) == 0);
    flush_tag = TAG_W'($urandom);
    flush_all = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    int n0;
    bit acc;
    checks = 0;
    failures = 0;
    rob_head = '0;
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   64'(cdb_valid), 64'd0);
    check("rst_tag",     64'(cdb_tag), 64'd0);
    check("rst_value",   cdb_value, 64'd0);
    check("rst_exc",     64'(cdb_exception), 64'd0);
    check("rst_cause",   64'(cdb_exc_cause), 64'd0);
    check("rst_ff",      64'(cdb_fflags), 64'd0);
    check("rst_ready",   64'(fu_ready), 64'hF);
    check("rst_pending", 64'(pending), 64'd0);
    rst_n = 1'b1;

    $display("[TB] single result latency");
    set_fu(1, 5'd3, 64'hDEAD);
    applyStimulus();
    clear_inputs();
    check("t1_early_valid", 64'(cdb_valid), 64'd0);
    applyStimulus();
    check("t1_valid", 64'(cdb_valid), 64'd1);
    check("t1_tag",   64'(cdb_tag), 64'd3);
    check("t1_value", cdb_value, 64'hDEAD);
    applyStimulus();
    check("t1_after_valid", 64'(cdb_valid), 64'd0);

    $display("[TB] age ordering across wrap and tie break");
    rob_head = 5'd30;
    set_fu(0, 5'd2, 64'h1002);
    set_fu(2, 5'd31, 64'h1031);
    applyStimulus();
    clear_inputs();
    applyStimulus();
    check("t2_first_tag", 64'(cdb_tag), 64'd31);
    applyStimulus();
    check("t2_second_tag", 64'(cdb_tag), 64'd2);
    set_fu(1, 5'd7, 64'h111);
    set_fu(3, 5'd7, 64'h333);
    applyStimulus();
    clear_inputs();
    applyStimulus();
    check("t2_tie_first", cdb_value, 64'h111);
    applyStimulus();
    check("t2_tie_second", cdb_value, 64'h333);

    $display("[TB] backpressure on FU0");
    rob_head = '0;
    n0 = 0;
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      if (c < 6) set_fu(1, TAG_W'(c + 1), 64'(c + 64'h200));
      if (n0 < 3) set_fu(0, TAG_W'(20 + n0), 64'(n0 + 64'h500));
      acc = (n0 < 3) && exp_ready[0];
      applyStimulus();
      if (acc) n0++;
    end
    clear_inputs();

    $display("[TB] partial flush");
    rob_head = '0;
    set_fu(0, 5'd4, 64'h44);
    set_fu(1, 5'd9, 64'h99);
    applyStimulus();
    clear_inputs();
    check("t4_pending_before", 64'(pending), 64'd2);
    flush_en = 1'b1;
    flush_tag = 5'd6;
    applyStimulus();
    clear_inputs();
    check("t4_tag4_valid", 64'(cdb_valid), 64'd1);
    check("t4_tag4", 64'(cdb_tag), 64'd4);
    check("t4_pending_after", 64'(pending), 64'd0);
    applyStimulus();
    check("t4_no_tag9", 64'(cdb_valid), 64'd0);

    $display("[TB] full flush with pending entries and pushes");
    for (int k = 0; k < NUM_FU; k++) set_fu(k, TAG_W'(10 + k), 64'(k + 64'h700));
    applyStimulus();
    for (int k = 0; k < NUM_FU; k++) set_fu(k, TAG_W'(20 + k), 64'(k + 64'h800));
    applyStimulus();
    check("t5_pending_before", 64'(pending), 64'd7);
    for (int k = 0; k < NUM_FU; k++) set_fu(k, TAG_W'(1 + k), 64'(k + 64'h900));
    flush_all = 1'b1;
    applyStimulus();
    clear_inputs();
    check("t5_valid", 64'(cdb_valid), 64'd0);
    check("t5_pending", 64'(pending), 64'd0);
    check("t5_ready", 64'(fu_ready), 64'hF);
    applyStimulus();
    check("t5_idle_valid", 64'(cdb_valid), 64'd0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      random_inputs();
      applyStimulus();
    end

    $display("[TB] async reset mid-stream");
    for (int k = 0; k < NUM_FU; k++) set_fu(k, TAG_W'(rob_head + k + 1), {$urandom, $urandom});
    applyStimulus();
    random_inputs();
    flush_all = 1'b0;
    flush_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(cdb_valid), 64'd0);
    check("t6_tag", 64'(cdb_tag), 64'd0);
    check("t6_value", cdb_value, 64'd0);
    check("t6_ff", 64'(cdb_fflags), 64'd0);
    check("t6_pending", 64'(pending), 64'd0);
    check("t6_ready", 64'(fu_ready), 64'hF);
    model_reset();
    clear_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    applyStimulus();
    applyStimulus();
    check("t6_quiet", 64'(cdb_valid), 64'd0);
    set_fu(2, TAG_W'(rob_head + 5), 64'hBEEF);
    applyStimulus();
    clear_inputs();
    check("t6_no_bypass", 64'(cdb_valid), 64'd0);
    applyStimulus();
    check("t6_first_valid", 64'(cdb_valid), 64'd1);
    check("t6_first_value", cdb_value, 64'hBEEF);

    for (int c = 0; c < 300; c++) begin
      random_inputs();
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
